// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word-aligned fetches under a credit limit,
// pairs each returned word with its request PC, and buffers the pairs for
// the decoder. A redirect flushes the buffer and discards in-flight returns.
module inst_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rdy,
   input  logic            imem_dv,
   input  logic [XLEN-1:0] imem_data,
   input  logic            flush_pipe,
   input  logic [XLEN-1:0] new_pc,
   input  logic            stall,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] cur_pc,
   output logic            inst_dv,
   output logic            misalign
);
   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [0:0]  RUN     = 1'b0;
   localparam logic [0:0]  DRAIN   = 1'b1;

   logic [0:0]      state;
   logic [XLEN-1:0] pc;

   // addresses of requests whose data has not come back yet
   logic [XLEN-1:0] pcq_mem [DEPTH];
   logic [AW-1:0]   pcq_wr, pcq_rd;
   logic [CW-1:0]   pcq_cnt;

   // decoded-side buffer of {instruction, pc}
   logic [XLEN-1:0] buf_inst [DEPTH];
   logic [XLEN-1:0] buf_pc   [DEPTH];
   logic [AW-1:0]   buf_wr, buf_rd;
   logic [CW-1:0]   buf_cnt;

   // responses still owed to requests issued before the last redirect
   logic [CW-1:0]   drop_cnt;

   logic            xfer, rsp, drop, push, pop;
   logic [CW:0]     flush_drops;

   assign imem_addr = pc;
   assign inst_dv   = (buf_cnt != '0);
   assign inst      = inst_dv ? buf_inst[buf_rd] : '0;
   assign cur_pc    = inst_dv ? buf_pc[buf_rd]   : '0;

   // handshake qualifiers; a request is only offered when its response has a guaranteed slot
   always_comb begin
      imem_req    = rst_n && (state == RUN) &&
                    (({1'b0, pcq_cnt} + {1'b0, buf_cnt}) < DEPTH_W);
      xfer        = imem_req && imem_rdy;
      // returns with nothing outstanding (e.g. leftovers across reset) are ignored
      rsp         = imem_dv && (state == RUN) && (pcq_cnt != '0);
      drop        = imem_dv && (state == DRAIN) && (drop_cnt != '0);
      push        = rsp && !flush_pipe;
      pop         = inst_dv && !stall && !flush_pipe;
      // everything in flight after this edge becomes a drop on a redirect
      flush_drops = {1'b0, drop_cnt} + {1'b0, pcq_cnt} + (CW+1)'(xfer)
                    - (CW+1)'(rsp) - (CW+1)'(drop);
   end

   // fetch PC, run/drain state, drop counter and misalignment pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         state    <= RUN;
         drop_cnt <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= flush_pipe && (new_pc[1:0] != 2'b00);
         if (flush_pipe) begin
            pc       <= {new_pc[XLEN-1:2], 2'b00};
            drop_cnt <= flush_drops[CW-1:0];
            state    <= (flush_drops != '0) ? DRAIN : RUN;
         end else begin
            if (xfer)
               pc <= pc + XLEN'(4);
            if (drop) begin
               drop_cnt <= drop_cnt - CW'(1);
               if (drop_cnt == CW'(1))
                  state <= RUN;
            end
         end
      end
   end

   // issued-address FIFO pointers; a redirect forgets all in-flight addresses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcq_wr  <= '0;
         pcq_rd  <= '0;
         pcq_cnt <= '0;
      end else if (flush_pipe) begin
         pcq_wr  <= '0;
         pcq_rd  <= '0;
         pcq_cnt <= '0;
      end else begin
         if (xfer) pcq_wr <= pcq_wr + AW'(1);
         if (rsp)  pcq_rd <= pcq_rd + AW'(1);
         pcq_cnt <= pcq_cnt + CW'(xfer) - CW'(rsp);
      end
   end

   // instruction buffer pointers; push and pop in one cycle leave occupancy unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_wr  <= '0;
         buf_rd  <= '0;
         buf_cnt <= '0;
      end else if (flush_pipe) begin
         buf_wr  <= '0;
         buf_rd  <= '0;
         buf_cnt <= '0;
      end else begin
         if (push) buf_wr <= buf_wr + AW'(1);
         if (pop)  buf_rd <= buf_rd + AW'(1);
         buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
      end
   end

   // storage arrays, validity is carried entirely by the pointers above
   always_ff @(posedge clk) begin
      if (xfer && !flush_pipe)
         pcq_mem[pcq_wr] <= pc;
      if (push) begin
         buf_inst[buf_wr] <= imem_data;
         buf_pc[buf_wr]   <= pcq_mem[pcq_rd];
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: the driver models memory and
// the expected program stream, the monitor checks what the decoder receives.
module tb_inst_fetch;
   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_rdy, imem_dv, flush_pipe, stall;
   logic        inst_dv, misalign;
   logic [31:0] imem_addr, imem_data, new_pc, inst, cur_pc;

   inst_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
      .imem_dv(imem_dv), .imem_data(imem_data),
      .flush_pipe(flush_pipe), .new_pc(new_pc), .stall(stall),
      .inst(inst), .cur_pc(cur_pc), .inst_dv(inst_dv), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

   pend_t       pend[$];   // requests the memory still has to answer
   exp_t        exp_q[$];  // program-order instructions not yet consumed
   int          n_pass = 0, n_chk = 0;
   int          cyc = 0, last_due = 0, consumed = 0, stale_cnt = 0;
   int          rdy_pct = 100, stall_pct = 0, lat_min = 1, lat_max = 1;
   bit          flush_req = 0, rst_req = 1;
   logic [31:0] flush_tgt = 32'h0;
   logic [31:0] want_pc = RESET_PC;
   bit          exp_mis = 0, hold_chk = 0;
   logic [31:0] hold_addr = 32'h0;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // one clock of memory behaviour plus stimulus knobs
   task automatic step();
      pend_t p;
      bit    busy;
      int    lat, due;
      @(negedge clk);
      cyc++;
      if (rst_n) check("misalign", 32'(misalign), 32'(exp_mis));
      exp_mis = 0;
      busy = (stale_cnt > 0);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         if (p.stale) stale_cnt--;
         imem_dv   = 1'b1;
         imem_data = memword(p.addr);
      end else begin
         imem_dv   = 1'b0;
         imem_data = $urandom;
      end
      imem_rdy   = ($urandom_range(99) < 32'(rdy_pct));
      stall      = ($urandom_range(99) < 32'(stall_pct));
      flush_pipe = flush_req;
      new_pc     = flush_req ? flush_tgt : $urandom;
      if (rst_req && rst_n) begin
         exp_q.delete();
         want_pc  = RESET_PC;
         hold_chk = 0;
         for (int i = 0; i < pend.size(); i++) pend[i].stale = 1;
         stale_cnt = 0;  // the block forgets these; they must simply be ignored
      end
      rst_n = !rst_req;
      #1;
      if (rst_n && busy) check("drain_no_req", 32'(imem_req), 32'd0);
      if (rst_n && hold_chk) check("addr_hold", imem_addr, hold_addr);
      if (rst_n && imem_req && imem_rdy) begin
         if (!flush_pipe) begin
            check("fetch_addr", imem_addr, want_pc);
            exp_q.push_back('{want_pc, memword(want_pc)});
            want_pc += 32'd4;
         end
         lat = int'($urandom_range(32'(lat_max), 32'(lat_min)));
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{imem_addr, due, 1'b0});
      end
      hold_chk  = rst_n && imem_req && !imem_rdy && !flush_pipe;
      hold_addr = imem_addr;
      if (flush_pipe) begin
         exp_q.delete();
         want_pc = {flush_tgt[31:2], 2'b00};
         exp_mis = |flush_tgt[1:0];
         for (int i = 0; i < pend.size(); i++) pend[i].stale = 1;
         stale_cnt = pend.size();
         flush_req = 0;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_addr",  imem_addr, RESET_PC);
      check("rst_inst",  inst, 32'd0);
      check("rst_pc",    cur_pc, 32'd0);
      check("rst_dv",    32'(inst_dv), 32'd0);
      check("rst_mis",   32'(misalign), 32'd0);
   endtask

   task automatic wait_dv(input string name, input logic [31:0] pc_exp);
      int guard = 0;
      do begin step(); guard++; end while (!inst_dv && guard < 60);
      check(name, cur_pc, pc_exp);
   endtask

   task automatic wait_pend(input int n);
      int guard = 0;
      do begin step(); guard++; end while (pend.size() < n && guard < 60);
      check("pend_reached", 32'(pend.size() >= n), 32'd1);
   endtask

   // monitor: every instruction the decoder takes must be the next one in program order
   initial begin : monitor
      exp_t        e;
      bit          held_v;
      logic [31:0] held_i, held_p;
      held_v = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n || !inst_dv) held_v = 0;
         else begin
            if (held_v) begin
               check("hold_inst", inst, held_i);
               check("hold_pc", cur_pc, held_p);
            end
            if (stall || flush_pipe) begin
               held_v = stall && !flush_pipe;
               held_i = inst;
               held_p = cur_pc;
            end else begin
               held_v = 0;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL stale_inst: got pc %h, expected no instruction", cur_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("cur_pc", cur_pc, e.pc);
                  check("inst", inst, e.word);
               end
               consumed++;
            end
         end
      end
   end

   initial begin
      int guard;
      int target;
      imem_rdy = 0; imem_dv = 0; imem_data = 0; flush_pipe = 0; new_pc = 0; stall = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) step();
      check_reset_outputs();

      // steady stream, 1-cycle memory: first instruction two cycles after the first request
      rdy_pct = 100; lat_min = 1; lat_max = 1; stall_pct = 0;
      rst_req = 0;
      step();
      check("first_req", 32'(imem_req), 32'd1);
      check("first_dv0", 32'(inst_dv), 32'd0);
      step();
      check("first_dv1", 32'(inst_dv), 32'd0);
      step();
      check("first_dv2", 32'(inst_dv), 32'd1);
      check("first_pc", cur_pc, RESET_PC);
      repeat (20) step();

      // long stall: credit limit holds exactly DEPTH in flight or buffered
      stall_pct = 100;
      repeat (10) step();
      check("stall_credit", 32'(exp_q.size()), 32'(DEPTH));
      check("stall_noreq", 32'(imem_req), 32'd0);
      stall_pct = 0;
      repeat (20) step();

      // redirect with requests in flight
      lat_min = 4; lat_max = 4;
      wait_pend(3);
      rdy_pct = 0; flush_req = 1; flush_tgt = 32'h100;
      step();
      rdy_pct = 100;
      wait_dv("flush_next_pc", 32'h100);
      repeat (10) step();

      // second redirect while still draining the first
      wait_pend(2);
      flush_req = 1; flush_tgt = 32'h200;
      step();
      flush_req = 1; flush_tgt = 32'h300;
      step();
      wait_dv("reflush_pc", 32'h300);
      repeat (10) step();

      // misaligned redirect target
      lat_min = 1; lat_max = 2;
      flush_req = 1; flush_tgt = 32'h103;
      step();
      step();
      check("misalign_seen", 32'(misalign), 32'd1);
      wait_dv("misalign_pc", 32'h100);
      repeat (10) step();

      // reset with requests outstanding
      lat_min = 3; lat_max = 3;
      wait_pend(2);
      rst_req = 1;
      step();
      check_reset_outputs();
      repeat (8) step();
      rst_req = 0;
      wait_dv("post_rst_pc", RESET_PC);

      // random traffic, including a redirect across the address wrap
      rdy_pct = 60; lat_min = 1; lat_max = 4; stall_pct = 30;
      flush_req = 1; flush_tgt = 32'hFFFF_FFF8;
      step();
      target = consumed + 2000;
      guard = 0;
      while (consumed < target && guard < 40000) begin
         if (!flush_req && $urandom_range(199) == 0) begin
            flush_req = 1;
            flush_tgt = $urandom & 32'h0000_FFFF;
         end
         step();
         guard++;
      end
      check("random_done", 32'(consumed >= target), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: instFetch

Interface
REQ-001 Parameter cXLEN, default 32, data/address width.
REQ-002 Parameter cResetPc, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter cDepth, default 4, instruction buffer depth and max outstanding requests (power of 2, >= 2).
REQ-004 iClk  in  1  single clock, all state on rising edge.
REQ-005 iRst  in  1  reset, asynchronous, active-low.
REQ-006 oImemReq  out  1  fetch request valid.
REQ-007 oImemAddr  out  cXLEN  fetch address, word aligned.
REQ-008 iImemRdy  in  1  memory accepts request this cycle.
REQ-009 iImemDv  in  1  read data valid, in request order.
REQ-010 iImemData  in  cXLEN  returned instruction word.
REQ-011 iFlushPipe  in  1  branch redirect from ALU writeback.
REQ-012 iNewPc  in  cXLEN  redirect target.
REQ-013 iStall  in  1  decoder cannot take an instruction this cycle.
REQ-014 oInst  out  cXLEN  instruction to decoder.
REQ-015 oCurPc  out  cXLEN  PC of oInst.
REQ-016 oInstDv  out  1  oInst/oCurPc valid.
REQ-017 oMisalign  out  1  one-cycle pulse, redirect target had bits [1:0] nonzero.

Function
REQ-018 Request handshake: a request is transferred when oImemReq=1 and iImemRdy=1; oImemAddr SHALL hold stable while oImemReq=1 and iImemRdy=0.
REQ-019 Fetch PC SHALL increment by 4 on each transferred request, wrapping 32'hFFFF_FFFC -> 0.
REQ-020 oImemReq SHALL be 1 only when outstanding + buffer occupancy < cDepth, so responses never overflow.
REQ-021 Each iImemDv SHALL write {iImemData, PC of that request} into the FIFO buffer; a PC FIFO tracks issued addresses.
REQ-022 oInstDv=1 whenever the buffer is non-empty; the head is popped on a cycle with oInstDv=1 and iStall=0.
REQ-023 While iStall=1, oInst, oCurPc and oInstDv SHALL hold unchanged.
REQ-024 Latency: request transferred at cycle N, response at N+k, oInstDv at N+k+1 if the buffer was empty.
REQ-025 Simultaneous push and pop on a full or empty buffer SHALL both succeed, occupancy unchanged.
REQ-026 FSM states: RUN (issuing), DRAIN (discarding stale responses); reset enters RUN.
REQ-027 On iFlushPipe=1: the buffer SHALL be cleared the same edge, and oInstDv=0 the next cycle.
REQ-027a On iFlushPipe=1: fetch PC <= {iNewPc[31:2],2'b00} and drop counter <= outstanding count including any request transferred that cycle.
REQ-027b On iFlushPipe=1: go to DRAIN if the drop counter is nonzero, else stay in RUN.
REQ-028 In DRAIN, each iImemDv SHALL decrement the drop counter without writing the buffer, and oImemReq=0.
REQ-028a In DRAIN, the block SHALL return to RUN when the counter reaches 0.
REQ-029 Flush in DRAIN SHALL reload the PC, keep pending drops, add newly transferred requests, and stay in DRAIN.
REQ-030 oMisalign SHALL pulse the cycle after a flush whose iNewPc[1:0] != 0.
REQ-031 Flush has priority over pop and push in the same cycle.

Reset
REQ-032 While iRst=0: oImemReq=0, oImemAddr=cResetPc, oInst=0, oCurPc=0, oInstDv=0, oMisalign=0, buffer empty, counters 0, state RUN.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding and buffered data; responses arriving during or after reset are ignored until the first request post-reset.
REQ-034 The first request SHALL be issued in the first cycle after iRst rises, at cResetPc.

Verification
REQ-035 Memory with 1-cycle latency, iImemRdy=1, iStall=0 -> oCurPc sequence 0,4,8,...; oInst matches memory; first oInstDv 2 cycles after the first request.
REQ-036 Hold iStall=1 for 10 cycles -> exactly cDepth requests outstanding or buffered; oInst held; no lost or duplicated PC after release.
REQ-037 Flush to 32'h100 with 3 outstanding requests -> 3 responses dropped; next oCurPc=32'h100; no stale instruction ever reaches oInstDv.
REQ-038 Flush to 32'h103 -> oMisalign pulses once; fetch resumes at 32'h100.
REQ-039 iImemRdy toggling randomly with 1-4 cycle latency, random iStall, 2000 instructions -> scoreboard shows in-order, gap-free PC/instruction pairs.
REQ-040 Assert iRst=0 with 2 outstanding requests -> outputs at reset values immediately; first post-reset oCurPc=cResetPc.
